data_bus_arbiter: RTL and testbench

Two-master to one-slave arbiter for the testbench data bus. It shares a single data_mem_model port between the core's data interface (master 0) and an auxiliary bench master (master 1, e.g. a backdoor loader or DMA model). Grants are round-robin and wait-state tolerant. An in-order route FIFO steers each rvalid/rdata/err response back to the master that issued the request.

---
 rtl/data_arb_pkg.sv | 18 +
 rtl/arb_route_fifo.sv | 56 +++++
 rtl/data_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_arb_pkg.sv
// rtl/data_arb_pkg.sv - shared types and constants for the two-master data bus arbiter
package data_arb_pkg;

  localparam int NumMasters = 2;

  typedef logic [0:0] master_id_t;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // The round-robin pointer hands priority to the master that did not just win
  function automatic master_id_t other_master(input master_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/arb_route_fifo.sv
// rtl/arb_route_fifo.sv - in-order route FIFO recording which master owns each outstanding transaction
module arb_route_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];

  // A pop frees the slot the same-cycle push may use, so a full FIFO still accepts push+pop
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally as Depth is a power of 2
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master round-robin data bus arbiter (DATA_ARB_FIXED_PRIO_EN: master 0 always wins)
module data_bus_arbiter
  import data_arb_pkg::*;
#(
  parameter int DataWidth      = 33,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NumMasters-1:0]                m_req_i,
  input  logic [NumMasters-1:0]                m_we_i,
  input  logic [NumMasters-1:0][3:0]           m_be_i,
  input  logic [NumMasters-1:0][AddrWidth-1:0] m_addr_i,
  input  logic [NumMasters-1:0][DataWidth-1:0] m_wdata_i,
  output logic [NumMasters-1:0]                m_gnt_o,
  output logic [NumMasters-1:0]                m_rvalid_o,
  output logic [DataWidth-1:0]                 m_rdata_o,
  output logic [NumMasters-1:0]                m_err_o,
  output logic                                 s_req_o,
  output logic                                 s_we_o,
  output logic [3:0]                           s_be_o,
  output logic [AddrWidth-1:0]                 s_addr_o,
  output logic [DataWidth-1:0]                 s_wdata_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_rvalid_i,
  input  logic [DataWidth-1:0]                 s_rdata_i,
  input  logic                                 s_err_i,
  output logic                                 protocol_err_o,
  output logic                                 busy_o
);

  arb_state_e state;
  master_id_t locked_sel;
  master_id_t idle_sel;
  master_id_t sel;
  master_id_t head;
  logic       sel_req;
  logic       grant;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

`ifndef DATA_ARB_FIXED_PRIO_EN
  master_id_t rr_ptr;
`endif

  // Pick a winner among current requesters; rr_ptr names the favoured master on a tie
  always_comb begin
    idle_sel = '0;
    if (m_req_i[0] && m_req_i[1]) begin
`ifdef DATA_ARB_FIXED_PRIO_EN
      idle_sel = '0;
`else
      idle_sel = rr_ptr;
`endif
    end else if (m_req_i[1]) begin
      idle_sel = 1'b1;
    end
  end

  // While locked the earlier choice is held so the slave sees a stable request
  assign sel     = (state == ARB_LOCKED) ? locked_sel : idle_sel;
  assign sel_req = m_req_i[sel];

  // Gate every combinational output with reset so outstanding activity vanishes at once
  assign s_req_o   = rstn_i & sel_req & (~fifo_full | s_rvalid_i);
  assign s_we_o    = rstn_i & m_we_i[sel];
  assign s_be_o    = rstn_i ? m_be_i[sel] : '0;
  assign s_addr_o  = rstn_i ? m_addr_i[sel] : '0;
  assign s_wdata_o = rstn_i ? m_wdata_i[sel] : '0;

  assign grant   = s_req_o & s_gnt_i;
  assign m_gnt_o = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign pop        = rstn_i & s_rvalid_i & ~fifo_empty;
  assign m_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign m_err_o    = (pop & s_err_i) ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign m_rdata_o  = rstn_i ? s_rdata_i : '0;
  assign busy_o     = ~fifo_empty;

  arb_route_fifo #(
    .Width (1),
    .Depth (MaxOutstanding)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (s_rvalid_i),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Arbitration FSM: lock a selection that was not granted; a dropped req releases the lock
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= ARB_IDLE;
      locked_sel     <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (s_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (sel_req && !grant) begin
            state      <= ARB_LOCKED;
            locked_sel <= sel;
          end
        end
        ARB_LOCKED: begin
          if (grant || !sel_req) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifndef DATA_ARB_FIXED_PRIO_EN
  // Hand priority to the other master after every granted transfer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= other_master(sel);
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

  localparam int DW = 33;
  localparam int AW = 32;

  logic                clk;
  logic                rstn;
  logic [1:0]          m_req;
  logic [1:0]          m_we;
  logic [1:0][3:0]     m_be;
  logic [1:0][AW-1:0]  m_addr;
  logic [1:0][DW-1:0]  m_wdata;
  logic [1:0]          m_gnt_o;
  logic [1:0]          m_rvalid_o;
  logic [DW-1:0]       m_rdata_o;
  logic [1:0]          m_err_o;
  logic                s_req_o;
  logic                s_we_o;
  logic [3:0]          s_be_o;
  logic [AW-1:0]       s_addr_o;
  logic [DW-1:0]       s_wdata_o;
  logic                s_gnt;
  logic                s_rvalid;
  logic [DW-1:0]       s_rdata;
  logic                s_err;
  logic                protocol_err_o;
  logic                busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h2000_0004;
  localparam logic [DW-1:0] W0 = 33'h0_1111_2222;
  localparam logic [DW-1:0] W1 = 33'h1_3333_4444;

  data_bus_arbiter #(
    .DataWidth      (DW),
    .AddrWidth      (AW),
    .MaxOutstanding (4)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .m_req_i        (m_req),
    .m_we_i         (m_we),
    .m_be_i         (m_be),
    .m_addr_i       (m_addr),
    .m_wdata_i      (m_wdata),
    .m_gnt_o        (m_gnt_o),
    .m_rvalid_o     (m_rvalid_o),
    .m_rdata_o      (m_rdata_o),
    .m_err_o        (m_err_o),
    .s_req_o        (s_req_o),
    .s_we_o         (s_we_o),
    .s_be_o         (s_be_o),
    .s_addr_o       (s_addr_o),
    .s_wdata_o      (s_wdata_o),
    .s_gnt_i        (s_gnt),
    .s_rvalid_i     (s_rvalid),
    .s_rdata_i      (s_rdata),
    .s_err_i        (s_err),
    .protocol_err_o (protocol_err_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    m_we      = 2'b10;
    m_be      = {4'hF, 4'h3};
    m_addr[0] = A0;
    m_addr[1] = A1;
    m_wdata[0] = W0;
    m_wdata[1] = W1;
    s_rdata   = '0;
    s_err     = 1'b0;
    m_req     = 2'b11;
    s_gnt     = 1'b1;
    s_rvalid  = 1'b1;

    // reset holds every output low despite live inputs
    @(negedge clk);
    check("rst_s_req", s_req_o, 0);
    check("rst_gnt", m_gnt_o, 0);
    check("rst_rvalid", m_rvalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_perr", protocol_err_o, 0);
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0;
    tick();
    rstn = 1'b1;

    // round robin with one-cycle response latency
    m_req = 2'b11; s_gnt = 1'b1;
    @(negedge clk);
    check("rr_gnt_c1", m_gnt_o, 2'b01);
    check("rr_addr_c1", s_addr_o, A0);
    check("rr_we_c1", s_we_o, 0);
    check("rr_be_c1", s_be_o, 4'h3);
    tick();
    s_rvalid = 1'b1; s_rdata = 33'h1_0000_00A1;
    @(negedge clk);
    check("rr_gnt_c2", m_gnt_o, 2'b10);
    check("rr_wdata_c2", s_wdata_o, W1);
    check("rr_rv_c2", m_rvalid_o, 2'b01);
    check("rr_rdata_c2", m_rdata_o, 33'h1_0000_00A1);
    tick();
    s_rdata = 33'h0_DEAD_BEEF;
    @(negedge clk);
    check("rr_gnt_c3", m_gnt_o, 2'b01);
    check("rr_rv_c3", m_rvalid_o, 2'b10);
    check("rr_rdata_c3", m_rdata_o, 33'h0_DEAD_BEEF);
    tick();
    @(negedge clk);
    check("rr_gnt_c4", m_gnt_o, 2'b10);
    check("rr_rv_c4", m_rvalid_o, 2'b01);
    tick();
    m_req = 2'b00;
    @(negedge clk);
    check("rr_gnt_c5", m_gnt_o, 2'b00);
    check("rr_rv_c5", m_rvalid_o, 2'b10);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    check("rr_busy_end", busy_o, 0);
    check("rr_perr_end", protocol_err_o, 0);

    // wait states: master 1 stays selected while master 0 joins
    m_req = 2'b10; s_gnt = 1'b0;
    @(negedge clk);
    check("lk_sreq_c1", s_req_o, 1);
    check("lk_gnt_c1", m_gnt_o, 2'b00);
    tick();
    m_req = 2'b11;
    @(negedge clk);
    check("lk_addr_c2", s_addr_o, A1);
    check("lk_gnt_c2", m_gnt_o, 2'b00);
    tick();
    @(negedge clk);
    check("lk_addr_c3", s_addr_o, A1);
    tick();
    s_gnt = 1'b1;
    @(negedge clk);
    check("lk_gnt_c4", m_gnt_o, 2'b10);
    tick();
    @(negedge clk);
    check("lk_gnt_c5", m_gnt_o, 2'b01);
    tick();
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
    @(negedge clk);
    check("lk_rv_1", m_rvalid_o, 2'b10);
    tick();
    @(negedge clk);
    check("lk_rv_0", m_rvalid_o, 2'b01);
    tick();
    s_rvalid = 1'b0;

    // fill the route FIFO, then push and pop together at full
    m_req = 2'b01; s_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fl_gnt_fill", m_gnt_o, 2'b01);
      tick();
    end
    @(negedge clk);
    check("fl_sreq_full", s_req_o, 0);
    check("fl_busy_full", busy_o, 1);
    check("fl_gnt_full", m_gnt_o, 2'b00);
    tick();
    s_rvalid = 1'b1;
    @(negedge clk);
    check("fl_sreq_pp", s_req_o, 1);
    check("fl_gnt_pp", m_gnt_o, 2'b01);
    check("fl_rv_pp", m_rvalid_o, 2'b01);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    check("fl_sreq_still_full", s_req_o, 0);
    tick();
    m_req = 2'b00; s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fl_rv_drain", m_rvalid_o, 2'b01);
      tick();
    end
    s_rvalid = 1'b0;
    @(negedge clk);
    check("fl_busy_drained", busy_o, 0);

    // error response routed to master 0
    m_req = 2'b01; s_gnt = 1'b1;
    @(negedge clk);
    check("er_gnt", m_gnt_o, 2'b01);
    tick();
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b1;
    @(negedge clk);
    check("er_err", m_err_o, 2'b01);
    check("er_rv", m_rvalid_o, 2'b01);
    tick();
    s_rvalid = 1'b0; s_err = 1'b0;

    // response with nothing outstanding
    @(negedge clk);
    check("em_perr_before", protocol_err_o, 0);
    s_rvalid = 1'b1;
    @(negedge clk);
    check("em_rv", m_rvalid_o, 2'b00);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    check("em_perr_set", protocol_err_o, 1);
    tick();
    @(negedge clk);
    check("em_perr_held", protocol_err_o, 1);
    check("em_busy", busy_o, 0);

    // reset with two transactions outstanding
    m_req = 2'b11; s_gnt = 1'b1;
    tick();
    tick();
    check("mr_busy_pre", busy_o, 1);
    rstn = 1'b0;
    #1;
    check("mr_busy", busy_o, 0);
    check("mr_sreq", s_req_o, 0);
    check("mr_gnt", m_gnt_o, 2'b00);
    check("mr_perr", protocol_err_o, 0);
    s_rvalid = 1'b1;
    #1;
    check("mr_rv", m_rvalid_o, 2'b00);
    m_req = 2'b00; s_gnt = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("mr_stale_rv", m_rvalid_o, 2'b00);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    check("mr_stale_perr", protocol_err_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
